// File: rtl/clock_monitor_pkg.sv
// Shared types and sizing helpers for the clock_monitor block and its sub-modules.
// Pulled in with import clock_monitor_pkg::*.
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMeasure = 2'd1,
        StReport  = 2'd2
    } state_e;

    // Width of the window counter: holds 0 .. window-1, never narrower than 1 bit.
    function automatic int unsigned win_cnt_width(input int unsigned window);
        return (window > 1) ? unsigned'($clog2(window)) : 1;
    endfunction

    // Width of the loss-of-clock counter: holds 0 .. timeout (saturation value).
    function automatic int unsigned lost_cnt_width(input int unsigned timeout);
        return unsigned'($clog2(timeout + 1));
    endfunction

endpackage

// File: rtl/clock_sync_edge.sv
// Three-flop synchronizer for an asynchronous level with an XOR edge detector.
// Both rising and falling transitions of din produce a one-cycle edge_det pulse.
module clock_sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic edge_det
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // s1 may be metastable; only s2 and s3 feed the detector.
    assign edge_det = s2_q ^ s3_q;

endmodule

// File: rtl/clock_monitor.sv
// Frequency / liveness monitor for a generated clock, observed through its divide-by-2 toggle.
// Define CLOCK_MONITOR_HIST_EN to add the min/max history outputs and the clrHist input.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int unsigned WINDOW       = 1024,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned MIN_CNT      = 480,
    parameter int unsigned MAX_CNT      = 544,
    parameter int unsigned LOST_TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enable,
    input  logic             toggleIn,
    output logic [CNT_W-1:0] measCount,
    output logic             measValid,
    output logic             inRange,
    output logic             clockLost
`ifdef CLOCK_MONITOR_HIST_EN
    ,
    input  logic             clrHist,
    output logic [CNT_W-1:0] measMin,
    output logic [CNT_W-1:0] measMax
`endif
);

    localparam int unsigned WinW  = win_cnt_width(WINDOW);
    localparam int unsigned LostW = lost_cnt_width(LOST_TIMEOUT);

    localparam logic [WinW-1:0]  WinLast = WinW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] MinCnt  = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] CntSat  = {CNT_W{1'b1}};
    localparam logic [LostW-1:0] LostMax = LostW'(LOST_TIMEOUT);
    localparam logic [LostW-1:0] LostSet = LostW'(LOST_TIMEOUT - 1);

    logic tog_edge;

    state_e           state_q, state_d;
    logic [WinW-1:0]  win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] meas_count_q, meas_count_d;
    logic             meas_valid_q, meas_valid_d;
    logic             in_range_q, in_range_d;
    logic [LostW-1:0] lost_cnt_q, lost_cnt_d;
    logic             clock_lost_q, clock_lost_d;

`ifdef CLOCK_MONITOR_HIST_EN
    logic [CNT_W-1:0] meas_min_q, meas_min_d;
    logic [CNT_W-1:0] meas_max_q, meas_max_d;
    logic [CNT_W-1:0] hist_min_base;
    logic [CNT_W-1:0] hist_max_base;
`endif

    clock_sync_edge u_sync (
        .CLK      (CLK),
        .RST      (RST),
        .din      (toggleIn),
        .edge_det (tog_edge)
    );

    // Window state machine and report registers.
    always_comb begin
        state_d      = state_q;
        win_cnt_d    = win_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        meas_count_d = meas_count_q;
        in_range_d   = in_range_q;
        meas_valid_d = 1'b0;
`ifdef CLOCK_MONITOR_HIST_EN
        // A clear coinciding with REPORT lands first, then the new sample is folded in.
        hist_min_base = clrHist ? CntSat : meas_min_q;
        hist_max_base = clrHist ? '0 : meas_max_q;
        meas_min_d    = hist_min_base;
        meas_max_d    = hist_max_base;
`endif

        unique case (state_q)
            StIdle: begin
                win_cnt_d  = '0;
                edge_cnt_d = '0;
                if (enable) begin
                    state_d = StMeasure;
                end
            end

            StMeasure: begin
                if (!enable) begin
                    // Abandon the partial window; published results stay untouched.
                    state_d    = StIdle;
                    win_cnt_d  = '0;
                    edge_cnt_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + WinW'(1);
                    if (tog_edge && (edge_cnt_q != CntSat)) begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                    if (win_cnt_q == WinLast) begin
                        state_d = StReport;
                    end
                end
            end

            StReport: begin
                meas_valid_d = 1'b1;
                meas_count_d = edge_cnt_q;
                in_range_d   = (edge_cnt_q >= MinCnt) && (edge_cnt_q <= MaxCnt);
                win_cnt_d    = '0;
                edge_cnt_d   = '0;
                state_d      = enable ? StMeasure : StIdle;
`ifdef CLOCK_MONITOR_HIST_EN
                meas_min_d = (edge_cnt_q < hist_min_base) ? edge_cnt_q : hist_min_base;
                meas_max_d = (edge_cnt_q > hist_max_base) ? edge_cnt_q : hist_max_base;
`endif
            end

            default: begin
                state_d    = StIdle;
                win_cnt_d  = '0;
                edge_cnt_d = '0;
            end
        endcase
    end

    // Loss-of-clock watchdog, free-running regardless of state or enable.
    always_comb begin
        lost_cnt_d   = lost_cnt_q;
        clock_lost_d = clock_lost_q;
        if (tog_edge) begin
            lost_cnt_d   = '0;
            clock_lost_d = 1'b0;
        end else begin
            if (lost_cnt_q != LostMax) begin
                lost_cnt_d = lost_cnt_q + LostW'(1);
            end
            if (lost_cnt_q >= LostSet) begin
                clock_lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            win_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
            in_range_q   <= 1'b0;
            lost_cnt_q   <= '0;
            clock_lost_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            meas_count_q <= meas_count_d;
            meas_valid_q <= meas_valid_d;
            in_range_q   <= in_range_d;
            lost_cnt_q   <= lost_cnt_d;
            clock_lost_q <= clock_lost_d;
        end
    end

`ifdef CLOCK_MONITOR_HIST_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            meas_min_q <= CntSat;
            meas_max_q <= '0;
        end else begin
            meas_min_q <= meas_min_d;
            meas_max_q <= meas_max_d;
        end
    end

    assign measMin = meas_min_q;
    assign measMax = meas_max_q;
`endif

    assign measCount = meas_count_q;
    assign measValid = meas_valid_q;
    assign inRange   = in_range_q;
    assign clockLost = clock_lost_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Self-checking bench for clock_monitor: randomized toggle streams checked against a
// history-based reference model (window counts, report timing, loss-of-clock).
module tb_clock_monitor;

    localparam int W    = 1024;
    localparam int CW   = 16;
    localparam int MINC = 480;
    localparam int MAXC = 544;
    localparam int LT   = 64;
    localparam int HLEN = 32768;

    logic          CLK = 1'b0;
    logic          RST;
    logic          enable;
    logic          toggleIn;
    logic [CW-1:0] measCount;
    logic          measValid;
    logic          inRange;
    logic          clockLost;
`ifdef CLOCK_MONITOR_HIST_EN
    logic          clrHist;
    logic [CW-1:0] measMin;
    logic [CW-1:0] measMax;
    logic [CW-1:0] hmin;
    logic [CW-1:0] hmax;
`endif

    clock_monitor #(
        .WINDOW       (W),
        .CNT_W        (CW),
        .MIN_CNT      (MINC),
        .MAX_CNT      (MAXC),
        .LOST_TIMEOUT (LT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (enable),
        .toggleIn  (toggleIn),
        .measCount (measCount),
        .measValid (measValid),
        .inRange   (inRange),
        .clockLost (clockLost)
`ifdef CLOCK_MONITOR_HIST_EN
        ,
        .clrHist   (clrHist),
        .measMin   (measMin),
        .measMax   (measMax)
`endif
    );

    always #5 CLK = ~CLK;

    // Per-clock record of what the DUT sampled; clock n is the posedge where cyc == n.
    bit v_hist[HLEN];
    bit r_hist[HLEN];
    int cyc = 0;

    always @(posedge CLK) begin
        if (cyc < HLEN) begin
            v_hist[cyc] <= toggleIn;
            r_hist[cyc] <= RST;
        end
        cyc <= cyc + 1;
    end

    always @(posedge CLK) begin
        if (cyc >= HLEN - 4) begin
            $display("FAIL watchdog cyc=%0d limit=%0d", cyc, HLEN - 4);
            $fatal(1, "cycle budget exhausted");
        end
    end

    // Toggle generator: 0 hold, 1 every cycle, 2 every second cycle, 3 random, 4 single shot.
    int tog_mode = 0;
    int tog_pct  = 50;
    int tog_at   = -1;

    initial begin
        toggleIn = 1'b0;
        forever begin
            @(negedge CLK);
            case (tog_mode)
                1: toggleIn = ~toggleIn;
                2: if (cyc % 2 == 0) toggleIn = ~toggleIn;
                3: if ($urandom_range(0, 99) < tog_pct) toggleIn = ~toggleIn;
                4: if (cyc == tog_at) toggleIn = ~toggleIn;
                default: ;
            endcase
        end
    end

    typedef struct {
        int idx;
        int cnt;
        bit inr;
    } rep_t;

    rep_t rq[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    bit   lost_chk = 1'b0;

    // Value held by the k-th synchronizer stage after clock n (k = 1..3).
    function automatic bit sync_at(int n, int k);
        for (int i = 0; i < k; i++) begin
            if (n - i < 0 || r_hist[n - i]) return 1'b0;
        end
        return v_hist[n - k + 1];
    endfunction

    // A toggle change between samples m-3 and m-2 is registered by the counters at clock m.
    function automatic bit edge_at(int m);
        return sync_at(m - 1, 2) ^ sync_at(m - 1, 3);
    endfunction

    function automatic int exp_count(int first, int last);
        int c = 0;
        for (int j = first; j <= last; j++) begin
            if (edge_at(j)) c++;
        end
        if (c > (1 << CW) - 1) c = (1 << CW) - 1;
        return c;
    endfunction

    // Lost after clock n iff LT consecutive clocks ending at n saw neither an edge nor reset.
    function automatic bit exp_lost(int n);
        for (int k = 0; k < LT; k++) begin
            if (n - k < 0) return 1'b0;
            if (r_hist[n - k] || edge_at(n - k)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Advance one cycle; sample outputs on the falling edge.
    task automatic tick();
        @(negedge CLK);
        if (measValid === 1'b1) rq.push_back('{cyc - 1, int'(measCount), inRange});
        if (lost_chk) begin
            n_cmp++;
            if (clockLost !== exp_lost(cyc - 1)) begin
                n_fail++;
                $display("FAIL clock_lost clk=%0d got=%b exp=%b", cyc - 1, clockLost,
                         exp_lost(cyc - 1));
            end
        end
    endtask

    // Windows start measuring the clock after m0; each occupies W+1 clocks including REPORT.
    task automatic check_windows(input int m0, input int nwin, input int lo, input int hi);
        rep_t r;
        int   exp_idx, first, e;
        for (int k = 0; k < nwin; k++) begin
            exp_idx = m0 + (k + 1) * (W + 1);
            first   = m0 + 1 + k * (W + 1);
            while (rq.size() == 0 && cyc <= exp_idx + 10) tick();
            n_cmp++;
            if (rq.size() == 0) begin
                n_fail++;
                $display("FAIL meas_valid_timeout got=none exp_clk=%0d", exp_idx);
                return;
            end
            r = rq.pop_front();
            e = exp_count(first, first + W - 1);
            if (r.idx !== exp_idx) begin
                n_fail++;
                $display("FAIL meas_valid_time got=%0d exp=%0d", r.idx, exp_idx);
            end
            n_cmp++;
            if (r.cnt !== e) begin
                n_fail++;
                $display("FAIL meas_count got=%0d exp=%0d", r.cnt, e);
            end
            n_cmp++;
            if (r.inr !== (e >= MINC && e <= MAXC)) begin
                n_fail++;
                $display("FAIL in_range got=%b exp=%b (count %0d)", r.inr,
                         (e >= MINC && e <= MAXC), e);
            end
            n_cmp++;
            if (r.cnt < lo || r.cnt > hi) begin
                n_fail++;
                $display("FAIL count_bounds got=%0d exp=%0d..%0d", r.cnt, lo, hi);
            end
`ifdef CLOCK_MONITOR_HIST_EN
            if (e < int'(hmin)) hmin = CW'(e);
            if (e > int'(hmax)) hmax = CW'(e);
            n_cmp++;
            if (measMin !== hmin || measMax !== hmax) begin
                n_fail++;
                $display("FAIL hist_minmax got=%0d/%0d exp=%0d/%0d", measMin, measMax, hmin,
                         hmax);
            end
`endif
        end
    endtask

    task automatic measure_windows(input int nwin, input int mode, input int lo, input int hi);
        int m0;
        tog_mode = mode;
        repeat (4) tick();
        enable = 1'b1;
        m0     = cyc;
        rq.delete();
        check_windows(m0, nwin, lo, hi);
        enable = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (rq.size() != 0) begin
            n_fail++;
            $display("FAIL extra_meas_valid got=%0d exp=0", rq.size());
        end
    endtask

    task automatic test_reset();
        RST    = 1'b1;
        enable = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (measCount !== '0 || measValid !== 1'b0 || inRange !== 1'b0 || clockLost !== 1'b0)
        begin
            n_fail++;
            $display("FAIL reset_outputs got=%0d/%b/%b/%b exp=0/0/0/0", measCount, measValid,
                     inRange, clockLost);
        end
        RST = 1'b0;
        tick();
        n_cmp++;
        if (measCount !== '0 || measValid !== 1'b0 || inRange !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got=%0d/%b/%b exp=0/0/0", measCount, measValid,
                     inRange);
        end
        lost_chk = 1'b1;
    endtask

    task automatic test_nominal();
        measure_windows(2, 2, 511, 513);
    endtask

    task automatic test_fast();
        measure_windows(1, 1, 1023, 1024);
        n_cmp++;
        if (clockLost !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_not_lost got=%b exp=0", clockLost);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            tog_pct = int'($urandom_range(44, 58));
            measure_windows(1, 3, 0, W);
        end
    endtask

    task automatic test_clock_lost();
        int t;
        tog_mode = 0;
        repeat (LT + 10) tick();
        n_cmp++;
        if (clockLost !== 1'b1) begin
            n_fail++;
            $display("FAIL lost_asserted got=%b exp=1", clockLost);
        end
        measure_windows(1, 0, 0, 0);
        tog_at   = cyc + 1;
        tog_mode = 4;
        t        = 0;
        while (clockLost !== 1'b0 && t < 10) begin
            tick();
            t++;
        end
        n_cmp++;
        if (clockLost !== 1'b0) begin
            n_fail++;
            $display("FAIL lost_recover got=%b exp=0 after %0d cycles", clockLost, t);
        end
        tog_mode = 0;
    endtask

    task automatic test_enable_drop();
        int            m0;
        logic [CW-1:0] saved;
        tog_mode = 2;
        repeat (4) tick();
        saved  = measCount;
        enable = 1'b1;
        m0     = cyc;
        rq.delete();
        while (cyc < m0 + 501) tick();
        enable = 1'b0;
        repeat (W + 20) tick();
        n_cmp++;
        if (rq.size() != 0) begin
            n_fail++;
            $display("FAIL drop_no_valid got=%0d exp=0", rq.size());
        end
        n_cmp++;
        if (measCount !== saved) begin
            n_fail++;
            $display("FAIL drop_count_kept got=%0d exp=%0d", measCount, saved);
        end
        measure_windows(1, 2, 511, 513);
    endtask

    task automatic test_reset_mid();
        int m0;
        tog_mode = 1;
        repeat (4) tick();
        enable = 1'b1;
        repeat (300) tick();
        RST = 1'b1;
        tick();
        n_cmp++;
        if (measCount !== '0 || measValid !== 1'b0 || inRange !== 1'b0 || clockLost !== 1'b0)
        begin
            n_fail++;
            $display("FAIL mid_reset_outputs got=%0d/%b/%b/%b exp=0/0/0/0", measCount,
                     measValid, inRange, clockLost);
        end
        RST = 1'b0;
        m0  = cyc;
        rq.delete();
`ifdef CLOCK_MONITOR_HIST_EN
        hmin = '1;
        hmax = '0;
`endif
        check_windows(m0, 1, 1020, 1024);
        enable = 1'b0;
        repeat (3) tick();
    endtask

`ifdef CLOCK_MONITOR_HIST_EN
    task automatic test_hist();
        tog_pct = 50;
        measure_windows(3, 3, 0, W);
        clrHist = 1'b1;
        tick();
        clrHist = 1'b0;
        hmin    = '1;
        hmax    = '0;
        n_cmp++;
        if (measMin !== {CW{1'b1}} || measMax !== '0) begin
            n_fail++;
            $display("FAIL hist_clear got=%0d/%0d exp=%0d/0", measMin, measMax, {CW{1'b1}});
        end
        measure_windows(1, 2, 511, 513);
    endtask
`endif

    initial begin
        RST    = 1'b1;
        enable = 1'b0;
`ifdef CLOCK_MONITOR_HIST_EN
        clrHist = 1'b0;
        hmin    = '1;
        hmax    = '0;
`endif
        test_reset();
        test_nominal();
        test_fast();
        test_random();
        test_clock_lost();
        test_enable_drop();
        test_reset_mid();
`ifdef CLOCK_MONITOR_HIST_EN
        test_hist();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
